// File: rtl/ram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for the show-ahead FIFO controller.
// The slave modport is the controller; master is its environment (producer, consumer, RAM).
interface ram_fifo_ctrl_if #(
  parameter int ADDR_SIZE = 7,
  parameter int DATA_SIZE = 16
);
  logic                 in_valid;
  logic [DATA_SIZE-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [DATA_SIZE-1:0] out_data;
  logic                 out_ready;
  logic                 ram_wren;
  logic [ADDR_SIZE-1:0] ram_waddr;
  logic [DATA_SIZE-1:0] ram_d;
  logic                 ram_rden;
  logic [ADDR_SIZE-1:0] ram_raddr;
  logic [DATA_SIZE-1:0] ram_q;
  logic [ADDR_SIZE:0]   level;

  modport slave (
    input  in_valid, in_data, out_ready, ram_q,
    output in_ready, out_valid, out_data, ram_wren, ram_waddr, ram_d,
           ram_rden, ram_raddr, level
  );

  modport master (
    output in_valid, in_data, out_ready, ram_q,
    input  in_ready, out_valid, out_data, ram_wren, ram_waddr, ram_d,
           ram_rden, ram_raddr, level
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Show-ahead FIFO controller for an external simple dual-port RAM with one cycle read latency.
// A head register plus one skid slot hide the RAM latency so the stream runs at 1 word/clk.
module ram_fifo_ctrl #(
  parameter int ADDR_SIZE = 7,
  parameter int DATA_SIZE = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  ram_fifo_ctrl_if.slave   bus
);
  localparam int CW = ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE:0] FULL_CNT = {1'b1, {ADDR_SIZE{1'b0}}};

  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE:0]   ram_cnt;
  logic                 pending;
  logic                 skid_valid;
  logic [DATA_SIZE-1:0] skid;
  logic                 out_valid_r;
  logic [DATA_SIZE-1:0] out_data_r;
  logic [ADDR_SIZE:0]   level_r;

  logic       in_ready_c;
  logic       push;
  logic       pop;
  logic       issue;
  logic [1:0] held;

  always_comb begin
    in_ready_c = (ram_cnt != FULL_CNT) & ~flush;
    push       = bus.in_valid & in_ready_c;
    pop        = out_valid_r & bus.out_ready;
    // words already committed to head/skid after this cycle's pop
    held       = 2'(out_valid_r) + 2'(skid_valid) + 2'(pending) - 2'(pop);
    issue      = (ram_cnt != '0) & (held < 2'd2) & ~flush;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.ram_wren  = push;
  assign bus.ram_waddr = wr_ptr;
  assign bus.ram_d     = bus.in_data;
  assign bus.ram_rden  = issue;
  assign bus.ram_raddr = rd_ptr;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.level     = level_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      pending     <= 1'b0;
      skid_valid  <= 1'b0;
      skid        <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      level_r     <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      pending     <= 1'b0;
      skid_valid  <= 1'b0;
      out_valid_r <= 1'b0;
      level_r     <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      if (issue) rd_ptr <= rd_ptr + ADDR_SIZE'(1);
      pending <= issue;
      ram_cnt <= ram_cnt + CW'(push) - CW'(issue);
      level_r <= level_r + CW'(push) - CW'(pop);

      if (pending) begin
        if (!(out_valid_r && !pop)) begin
          out_valid_r <= 1'b1;
          if (skid_valid) begin
            out_data_r <= skid;
            skid       <= bus.ram_q;
          end else begin
            out_data_r <= bus.ram_q;
          end
        end else begin
          skid       <= bus.ram_q;
          skid_valid <= 1'b1;
        end
      end else if (pop) begin
        if (skid_valid) begin
          out_data_r <= skid;
          skid_valid <= 1'b0;
        end else begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, queue scoreboard and word-count model,
// driven by directed and $urandom stimulus.
module tb_ram_fifo_ctrl;
  localparam int AW    = 7;
  localparam int DW    = 16;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();
  ram_fifo_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus)
  );

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q_r;
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_waddr] <= bus.ram_d;
    if (bus.ram_rden) q_r <= mem[bus.ram_raddr];
  end
  assign bus.ram_q = q_r;

  int n_pass = 0;
  int n_fail = 0;

  // reference model: ordered contents, total words held, words sitting in RAM, address counters
  logic [DW-1:0] exp_q[$];
  int exp_level, ram_words, wa_m, ra_m;
  logic hold_prev;
  logic [DW-1:0] hold_data;
  int bad_data, bad_proto, bad_level;

  logic          s_wren, s_rden, s_ov, s_ir, pushed, popped;
  logic [AW-1:0] s_waddr, s_raddr;
  logic [DW-1:0] s_od;

  task automatic model_clear();
    exp_q.delete();
    exp_level = 0; ram_words = 0; wa_m = 0; ra_m = 0; hold_prev = 1'b0;
  endtask

  task automatic clear_bad();
    bad_data = 0; bad_proto = 0; bad_level = 0;
  endtask

  // one clock cycle: apply inputs at negedge, sample and update the model, check level after posedge
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy; flush = fl;
    #1;
    s_ir = bus.in_ready; s_wren = bus.ram_wren; s_waddr = bus.ram_waddr;
    s_rden = bus.ram_rden; s_raddr = bus.ram_raddr; s_ov = bus.out_valid; s_od = bus.out_data;
    pushed = iv & s_ir;
    popped = s_ov & ordy;
    if (hold_prev && (s_ov !== 1'b1 || s_od !== hold_data)) bad_data++;
    if (s_ir !== (!fl && ram_words < DEPTH)) bad_proto++;
    if (s_wren !== pushed || (pushed && (s_waddr !== AW'(wa_m) || bus.ram_d !== d))) bad_proto++;
    if (s_rden === 1'b1 && (ram_words == 0 || s_raddr !== AW'(ra_m))) bad_proto++;
    if (fl && s_rden !== 1'b0) bad_proto++;
    if (popped) begin
      if (exp_q.size() == 0) bad_data++;
      else begin
        if (s_od !== exp_q[0]) bad_data++;
        void'(exp_q.pop_front());
      end
    end
    if (fl) model_clear();
    else begin
      if (pushed) begin
        exp_q.push_back(d); wa_m = (wa_m + 1) % DEPTH; ram_words++;
      end
      if (s_rden === 1'b1) begin
        ra_m = (ra_m + 1) % DEPTH; ram_words--;
      end
      exp_level = exp_level + int'(pushed) - int'(popped);
      hold_prev = s_ov & ~ordy;
      hold_data = s_od;
    end
    if (exp_level > DEPTH + 2) bad_level++;
    @(posedge clk);
    #1;
    if (bus.level !== (AW+1)'(exp_level)) bad_level++;
  endtask

  task automatic drain(input string tag, input int budget);
    int cyc = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && cyc < budget) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      cyc++;
    end
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_drain: %0d words left, out_valid %b, want 0 and 0", tag, exp_q.size(), bus.out_valid);
    end else n_pass++;
  endtask

  task automatic model_verdict(input string tag);
    if (bad_data != 0 || bad_proto != 0 || bad_level != 0) begin
      n_fail++;
      $display("FAIL %s_model: data/proto/level errors %0d/%0d/%0d, want 0/0/0", tag, bad_data, bad_proto, bad_level);
    end else n_pass++;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; flush = 1'b0;
    reset_n = 1'b0;
    #12;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end else n_pass++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end else n_pass++;
    if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end else n_pass++;
    if (bus.level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", bus.level); end else n_pass++;
    if (bus.ram_wren !== 1'b0 || bus.ram_rden !== 1'b0) begin
      n_fail++; $display("FAIL reset_ram_en: wren %b rden %b want 0 0", bus.ram_wren, bus.ram_rden);
    end else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_single_word();
    clear_bad();
    drive(1'b1, 16'h0001, 1'b1, 1'b0);
    if (s_wren !== 1'b1 || s_waddr !== '0) begin n_fail++; $display("FAIL single_write: wren %b waddr %0d want 1 0", s_wren, s_waddr); end else n_pass++;
    drive(1'b0, '0, 1'b1, 1'b0);
    if (s_rden !== 1'b1 || s_raddr !== '0) begin n_fail++; $display("FAIL single_read: rden %b raddr %0d want 1 0", s_rden, s_raddr); end else n_pass++;
    drive(1'b0, '0, 1'b1, 1'b0);
    if (s_ov !== 1'b0) begin n_fail++; $display("FAIL single_early: out_valid %b in cycle 2 want 0", s_ov); end else n_pass++;
    drive(1'b0, '0, 1'b1, 1'b0);
    if (s_ov !== 1'b1 || s_od !== 16'h0001) begin n_fail++; $display("FAIL single_out: valid %b data %h want 1 0001", s_ov, s_od); end else n_pass++;
    if (bus.level !== '0) begin n_fail++; $display("FAIL single_level: got %0d want 0", bus.level); end else n_pass++;
    model_verdict("single");
  endtask

  task automatic test_fill_full();
    int acc = 0;
    clear_bad();
    for (int i = 0; i < 140; i++) begin
      drive(1'b1, DW'(acc), 1'b0, 1'b0);
      if (pushed) acc++;
    end
    if (acc != DEPTH + 2) begin n_fail++; $display("FAIL full_accepted: got %0d want %0d", acc, DEPTH + 2); end else n_pass++;
    if (s_ir !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", s_ir); end else n_pass++;
    if (bus.level !== (AW+1)'(DEPTH + 2)) begin n_fail++; $display("FAIL full_level: got %0d want %0d", bus.level, DEPTH + 2); end else n_pass++;
    drain("full", 400);
    model_verdict("full");
  endtask

  task automatic test_back_to_back();
    int gaps = 0;
    int pops = 0;
    int val = 0;
    clear_bad();
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, DW'(val), 1'b1, 1'b0);
      if (pushed) val++;
      if (popped) pops++;
      if (i >= 3 && !s_ov) gaps++;
    end
    if (gaps != 0) begin n_fail++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end else n_pass++;
    if (pops != 997) begin n_fail++; $display("FAIL b2b_pops: got %0d want 997", pops); end else n_pass++;
    drain("b2b", 20);
    model_verdict("b2b");
  endtask

  task automatic test_random();
    int acc = 0;
    int cyc = 0;
    clear_bad();
    while (acc < 10000 && cyc < 60000) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
      if (pushed) acc++;
      cyc++;
    end
    if (acc != 10000) begin n_fail++; $display("FAIL random_words: got %0d want 10000", acc); end else n_pass++;
    drain("random", 400);
    model_verdict("random");
  endtask

  task automatic test_flush();
    int cyc = 0;
    logic got;
    logic [DW-1:0] first;
    clear_bad();
    for (int i = 0; i < 50; i++) drive(1'b1, DW'(16'h1000 + i), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    if (s_rden !== 1'b1) begin n_fail++; $display("FAIL flush_inflight: rden %b before flush want 1", s_rden); end else n_pass++;
    drive(1'b0, '0, 1'b0, 1'b1);
    if (s_ir !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", s_ir); end else n_pass++;
    if (bus.level !== '0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear: level %0d out_valid %b want 0 0", bus.level, bus.out_valid);
    end else n_pass++;
    drive(1'b1, 16'hBEEF, 1'b1, 1'b0);
    got = 1'b0; first = '0;
    while (!got && cyc < 10) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      if (popped) begin got = 1'b1; first = s_od; end
      cyc++;
    end
    if (!got || first !== 16'hBEEF) begin n_fail++; $display("FAIL flush_first: got %h (seen %b) want beef", first, got); end else n_pass++;
    drain("flush", 20);
    model_verdict("flush");
  endtask

  task automatic test_async_reset();
    clear_bad();
    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 1)), DW'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
    @(posedge clk);
    #3;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    if (bus.out_valid !== 1'b0 || bus.level !== '0) begin
      n_fail++; $display("FAIL areset_state: out_valid %b level %0d want 0 0", bus.out_valid, bus.level);
    end else n_pass++;
    if (bus.in_ready !== 1'b1 || bus.ram_wren !== 1'b0 || bus.ram_rden !== 1'b0) begin
      n_fail++; $display("FAIL areset_ports: in_ready %b wren %b rden %b want 1 0 0", bus.in_ready, bus.ram_wren, bus.ram_rden);
    end else n_pass++;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    model_clear();
    clear_bad();
    drive(1'b1, 16'h1234, 1'b1, 1'b0);
    if (s_wren !== 1'b1 || s_waddr !== '0) begin n_fail++; $display("FAIL areset_waddr: wren %b waddr %0d want 1 0", s_wren, s_waddr); end else n_pass++;
    drive(1'b1, 16'h5678, 1'b1, 1'b0);
    if (s_rden !== 1'b1 || s_raddr !== '0) begin n_fail++; $display("FAIL areset_raddr: rden %b raddr %0d want 1 0", s_rden, s_raddr); end else n_pass++;
    drain("areset", 20);
    model_verdict("areset");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    clear_bad();
    test_reset();
    test_single_word();
    test_fill_full();
    test_back_to_back();
    test_random();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Show-ahead FIFO controller that drives the write and read ports of an external simple dual-port block RAM, which has one cycle of read latency and an unregistered q.
- Presents valid/ready streaming interfaces on both sides, and hides RAM read latency with a 2-entry output skid so throughput is sustained at 1 word/clk.
- Sits between sample producers (decimator / ADC capture) and consumers (FIR MAC, audio DAC path) in the receiver datapath.

Parameters:
ADDR_SIZE, 7, RAM address width; RAM depth = 2**ADDR_SIZE words
DATA_SIZE, 16, data word width

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all contents; dominates all other inputs
in_valid  in  1  producer has a word
in_data  in  DATA_SIZE  producer word
in_ready  out  1  controller can accept a word
out_valid  out  1  out_data holds the head word
out_data  out  DATA_SIZE  head word, registered
out_ready  in  1  consumer accepts the head word
ram_wren  out  1  RAM write enable
ram_waddr  out  ADDR_SIZE  RAM write address
ram_d  out  DATA_SIZE  RAM write data
ram_rden  out  1  RAM read enable
ram_raddr  out  ADDR_SIZE  RAM read address
ram_q  in  DATA_SIZE  RAM read data; valid the cycle after the rden edge
level  out  ADDR_SIZE+1  total words held (RAM + in flight + skid), registered

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_ptr = rd_ptr = ram_cnt = 0; pending = 0.
  - out_valid = 0, skid_valid = 0, out_data = 0, level = 0.
  - Outputs in_ready = 1, ram_wren = 0, ram_rden = 0.
- Write:
  - push = in_valid & in_ready.
  - in_ready = (ram_cnt != 2**ADDR_SIZE) & ~flush, combinational from registers only.
  - ram_wren = push; ram_waddr = wr_ptr; ram_d = in_data (combinational).
  - wr_ptr increments mod 2**ADDR_SIZE on push.
- Read issue:
  - pop = out_valid & out_ready.
  - held = out_valid + skid_valid + pending − pop.
  - issue = (ram_cnt != 0) & (held < 2) & ~flush.
  - ram_rden = issue; ram_raddr = rd_ptr; rd_ptr increments mod depth on issue; pending <= issue.
- RAM count:
  - ram_cnt <= ram_cnt + push − issue.
  - A word is never read in the cycle it is written (ram_cnt updates at the write edge), so the mixed-port read-during-write collision cannot occur.
- Return path, in a cycle with pending = 1 (ram_q valid):
  - If (out_valid & ~pop) is false, the head slot is free: if skid_valid, out_data <= skid and skid <= ram_q; otherwise out_data <= ram_q.
  - If the head is occupied and not popped, skid <= ram_q and skid_valid <= 1.
  - Without pending: on pop, the skid moves to the head if skid_valid, otherwise out_valid <= 0.
- Ordering is strict FIFO. The skid is never overwritten while valid; the held < 2 rule guarantees this.
- Latency: word pushed in cycle N, with the FIFO empty and out_ready = 1, gives out_valid = 1 in cycle N+3.
- Throughput: with continuous push and pop, 1 word/clk in steady state.
- Full: ram_cnt = 2**ADDR_SIZE → in_ready = 0. Maximum level = 2**ADDR_SIZE + 2.
- Simultaneous push and issue: allowed; ram_cnt is unchanged.
- out_data and out_valid are stable while out_valid & ~out_ready.
- flush (registered effect):
  - All pointers, counts, pending, out_valid, skid_valid and level go to 0.
  - A RAM read in flight is discarded.
  - in_ready = 0 and ram_rden = 0 during the flush cycle.
- level <= level + push − pop (0 on flush).

Test Plan:
1. Reset, then push 0x0001 in cycle 0 with out_ready = 1 → ram_wren = 1 with waddr 0 in cycle 0; ram_rden = 1 with raddr 0 in cycle 1; out_valid = 1 with out_data 0x0001 in cycle 3; level returns to 0 after the pop.
2. ADDR_SIZE = 7, out_ready = 0, push 0..129 continuously → 130 words accepted (128 RAM + 2 skid); in_ready = 0 afterwards; level = 130; then drain gives 0..129 in order.
3. Continuous push and pop of an incrementing pattern for 1000 cycles with out_ready = 1 → one word out per clk after a 3-cycle fill; no gaps; no reorder; pointers wrap 127→0 correctly.
4. Random in_valid/out_ready (50%) over 10,000 words → scoreboard matches; the skid is never overwritten; ram_rden never issued with ram_cnt = 0.
5. Assert flush with 50 words held and a read pending → next cycle level = 0, out_valid = 0; the stale ram_q is ignored; the next pushed word 0xBEEF emerges first.
6. Drop reset_n mid-stream, asynchronously between edges → outputs go to reset values immediately; after release, the FIFO operates from empty with pointers at 0.
